player_bullet_ctrl: RTL

- Owns the single player bullet: launches it on a fire-key press, advances it upward once per video frame, retires it at the top of the screen or on a collision hit, then enforces a reload cooldown.
- Sits directly upstream of color_mapper and drives its bullet_in, bulletX and bulletY inputs.
- Also reports shot events to the score and sound logic.
- The screen is 640x480, origin top-left.

---
 rtl/player_bullet_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/player_bullet_ctrl.sv
// Player bullet controller: launches on a fire press, climbs BULLET_STEP px per frame, retires on top exit or hit, then reloads.
// Latency: launch 1 Clk after the press edge; frame_clk edge to frame_tick 3 Clk, position update on the following Clk.
// Backpressure: none; presses outside IDLE are dropped and hit is ignored outside FLY.
module player_bullet_ctrl #(
    parameter int unsigned BULLET_STEP     = 4,
    parameter int unsigned BULLET_LEN      = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] playerX,
    input  logic [9:0] playerY,
    input  logic       hit,
    output logic       bullet_in,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       shot_pulse,
    output logic [7:0] shots_fired
);

    localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
    localparam logic [9:0]    STEP    = 10'(BULLET_STEP);
    localparam logic [9:0]    LEN     = 10'(BULLET_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t        state_q;
    logic          fs1_q, fs2_q, fs3_q, frame_tick_q;
    logic          fire_prev_q;
    logic          bullet_in_q;
    logic [9:0]    bullet_x_q, bullet_y_q;
    logic          shot_pulse_q;
    logic [7:0]    shots_q;
    logic [CW-1:0] cd_cnt_q;

    logic          fire_edge;
    logic [9:0]    launch_y_d;
    logic [9:0]    fly_y_d;

    // frame_clk crosses into Clk through two flops; a third flop finds the rising edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fs1_q        <= 1'b0;
            fs2_q        <= 1'b0;
            fs3_q        <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            fs1_q        <= frame_clk;
            fs2_q        <= fs1_q;
            fs3_q        <= fs2_q;
            frame_tick_q <= fs2_q & ~fs3_q;
        end
    end

    // previous fire level; resets high so a key held through reset must be released first
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fire_prev_q <= 1'b1;
        end else begin
            fire_prev_q <= fire;
        end
    end

    // press edge, launch row one bullet length above the cannon (clamped at row 0), next flight row
    always_comb begin
        fire_edge  = fire & ~fire_prev_q;
        launch_y_d = (playerY < LEN) ? 10'd0 : (playerY - LEN);
        fly_y_d    = bullet_y_q - STEP;
    end

    // bullet lifecycle: IDLE -> FLY -> COOLDOWN -> IDLE, all outputs registered here
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            bullet_in_q  <= 1'b0;
            bullet_x_q   <= 10'd0;
            bullet_y_q   <= 10'd0;
            shot_pulse_q <= 1'b0;
            shots_q      <= 8'd0;
            cd_cnt_q     <= '0;
        end else begin
            shot_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire_edge) begin
                        state_q      <= FLY;
                        bullet_in_q  <= 1'b1;
                        bullet_x_q   <= playerX;
                        bullet_y_q   <= launch_y_d;
                        shot_pulse_q <= 1'b1;
                        shots_q      <= shots_q + 8'd1;
                    end
                end
                FLY: begin
                    // a hit wins over motion; the top check stops the row from wrapping below 0
                    if (hit || (frame_tick_q && (bullet_y_q < STEP))) begin
                        state_q     <= COOLDOWN;
                        bullet_in_q <= 1'b0;
                        cd_cnt_q    <= CD_LOAD;
                    end else if (frame_tick_q) begin
                        bullet_y_q <= fly_y_d;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else if (frame_tick_q) begin
                        cd_cnt_q <= cd_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    bullet_in_q <= 1'b0;
                end
            endcase
        end
    end

    assign bullet_in   = bullet_in_q;
    assign bulletX     = bullet_x_q;
    assign bulletY     = bullet_y_q;
    assign shot_pulse  = shot_pulse_q;
    assign shots_fired = shots_q;

endmodule
